// File: rtl/mult_arbiter_seq.sv
// mult_arbiter_seq
// Round-robin front end that shares one iterative shift-add multiplier
// between NREQ requesters and returns id-tagged products over a
// valid/ready response channel.
// Optional build macro: MULT_ARB_EARLY_EXIT_EN -- when defined, CALC ends as
// soon as the remaining multiplier bits are all zero (minimum one cycle).
module mult_arbiter_seq #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_result,
    output logic                  busy
);

    localparam int PW   = 2 * WIDTH;
    localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDW-1:0]   rr_ptr_r;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CNTW-1:0]  count_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [PW-1:0]    rsp_result_r;
    logic             rsp_valid_r;
    logic             busy_r;

    logic             win_found_s;
    logic [IDW-1:0]   win_id_s;
    logic [IDW:0]     scan_idx_s;
    logic [WIDTH-1:0] win_a_s;
    logic [WIDTH-1:0] win_b_s;
    logic [IDW-1:0]   rr_nxt_s;
    logic             accept_s;
    logic [PW-1:0]    acc_nxt_s;
    logic [WIDTH-1:0] mplier_nxt_s;
    logic             calc_exit_s;

    // Round-robin scan: first valid requester at or after rr_ptr_r (mod NREQ) wins.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = {IDW{1'b0}};
        scan_idx_s  = {(IDW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (scan_idx_s >= (IDW+1)'(NREQ)) begin
                scan_idx_s = scan_idx_s - (IDW+1)'(NREQ);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found_s && req_valid[j] && (scan_idx_s == (IDW+1)'(j))) begin
                    win_found_s = 1'b1;
                    win_id_s    = IDW'(j);
                end else begin
                    win_found_s = win_found_s;
                end
            end
        end
    end

    // Select the winning requester's operand slices.
    always_comb begin
        win_a_s = {WIDTH{1'b0}};
        win_b_s = {WIDTH{1'b0}};
        for (int j = 0; j < NREQ; j++) begin
            if (win_id_s == IDW'(j)) begin
                win_a_s = req_a[j*WIDTH +: WIDTH];
                win_b_s = req_b[j*WIDTH +: WIDTH];
            end else begin
                win_a_s = win_a_s;
            end
        end
    end

    // Grant decode (only in IDLE) and the pointer value following the winner.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        accept_s  = 1'b0;
        if ((state_r == ST_IDLE) && win_found_s) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
            accept_s  = 1'b1;
        end else begin
            accept_s  = 1'b0;
        end
        if (win_id_s == IDW'(NREQ - 1)) begin
            rr_nxt_s = {IDW{1'b0}};
        end else begin
            rr_nxt_s = win_id_s + {{(IDW-1){1'b0}}, 1'b1};
        end
    end

    // One shift-add step and the CALC termination condition.
    always_comb begin
        if (mplier_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
        mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
`ifdef MULT_ARB_EARLY_EXIT_EN
        calc_exit_s = (count_r == CNTW'(WIDTH - 1)) || (mplier_nxt_s == {WIDTH{1'b0}});
`else
        calc_exit_s = (count_r == CNTW'(WIDTH - 1));
`endif
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (calc_exit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture, shift-add datapath and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r     <= {IDW{1'b0}};
            acc_r        <= {PW{1'b0}};
            mcand_r      <= {PW{1'b0}};
            mplier_r     <= {WIDTH{1'b0}};
            count_r      <= {CNTW{1'b0}};
            rsp_id_r     <= {IDW{1'b0}};
            rsp_result_r <= {PW{1'b0}};
            rsp_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mcand_r  <= {{WIDTH{1'b0}}, win_a_s};
                        mplier_r <= win_b_s;
                        acc_r    <= {PW{1'b0}};
                        count_r  <= {CNTW{1'b0}};
                        rsp_id_r <= win_id_s;
                        rr_ptr_r <= rr_nxt_s;
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    mplier_r <= mplier_nxt_s;
                    count_r  <= count_r + {{(CNTW-1){1'b0}}, 1'b1};
                    if (calc_exit_s) begin
                        rsp_result_r <= acc_nxt_s;
                        rsp_valid_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mult_arbiter_seq.sv
// Self-checking bench for mult_arbiter_seq: expected responses are pushed to a
// scoreboard at grant time and popped when the DUT hands a result over.
module tb_mult_arbiter_seq;

    localparam int W    = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 3;
`ifdef MULT_ARB_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_result;
    logic              busy;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2*W-1:0] res;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   k;

    always #5 clk = ~clk;

    mult_arbiter_seq #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected cycles from accept edge to rsp_valid.
    function automatic int exp_lat(input logic [W-1:0] b);
        int h;
        h = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) h = i;
        end
        return EARLY ? (h + 1) : W;
    endfunction

    task automatic set_ops(input int id, input int a, input int b);
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
    endtask

    task automatic push_exp(input int id, input int a, input int b);
        exp_t e;
        e.id  = IDW'(id);
        e.res = (2*W)'(a * b);
        sb_q.push_back(e);
    endtask

    // Issue one request from a posedge+1 start; returns at the negedge where rsp_valid is seen.
    task automatic do_req(input int id, input int a, input int b);
        int cnt;
        int lat;
        set_ops(id, a, b);
        req_valid[id] = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!req_ready[id] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("grant", 32'(req_ready[id]), 32'd1);
        push_exp(id, a, b);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        set_ops(id, a ^ 15, b ^ 15);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 32'(lat), 32'(exp_lat(W'(b))));
    endtask

    task automatic single(input int id, input int a, input int b);
        do_req(id, a, b);
        @(negedge clk);
        check_eq("idle_after_rsp", 32'(busy), 32'd0);
        check_eq("valid_drop", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("drain", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard and one-hot grant watch.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_eq("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check_eq("rsp_result", 32'(rsp_result), 32'(mon_e.res));
            end
        end
        if (req_ready != 0) begin
            check_eq("onehot", 32'($countones(req_ready)), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(req_ready), 32'd0);
            check_eq("idle_valid", 32'(rsp_valid), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_result", 32'(rsp_result), 32'd0);
        end
        @(posedge clk);
        #1;

        // Single requests
        rsp_ready = 1'b1;
        single(0, 7, 9);
        single(0, 15, 15);
        single(0, 0, 13);

        // Alternation from a fresh pointer
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_ops(0, 3, 5);
        set_ops(1, 6, 7);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            @(negedge clk);
            while (req_ready == 0 && k < 50) begin
                @(negedge clk);
                k++;
            end
            check_eq("alt_grant", 32'(req_ready), 32'(1 << (g % 2)));
            if ((g % 2) == 0) push_exp(0, 3, 5);
            else              push_exp(1, 6, 7);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_idle();

        // Backpressure with a competing request held pending
        rsp_ready = 1'b0;
        set_ops(1, 12, 11);
        req_valid[1] = 1'b1;
        k = 0;
        @(negedge clk);
        while (req_ready == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("bp_grant", 32'(req_ready), 32'd2);
        push_exp(1, 12, 11);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        set_ops(0, 2, 3);
        req_valid[0] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_id", 32'(rsp_id), 32'd1);
            check_eq("bp_result", 32'(rsp_result), 32'd132);
            check_eq("bp_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_drop", 32'(rsp_valid), 32'd0);
        k = 0;
        while (!req_ready[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("bp_next_grant", 32'(req_ready), 32'd1);
        push_exp(0, 2, 3);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_idle();

        // Reset during CALC aborts the operation
        set_ops(0, 9, 7);
        req_valid[0] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req_ready[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_result", 32'(rsp_result), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        set_ops(0, 5, 3);
        set_ops(1, 1, 1);
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("rst_rr_ptr", 32'(req_ready), 32'd1);
        push_exp(0, 5, 3);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        // Operand-dependent latency
        single(0, 5, 1);
        single(0, 9, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mult_arbiter_seq.md
Name: mult_arbiter_seq

Overview:
- Shares one iterative shift-add multiplier between NREQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- The block captures operands, runs the shift-add sequence, and returns the product tagged with the requester id over a valid/ready response channel.
- Sits between client blocks and the arithmetic datapath as its sole sequencer.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of requester id field; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  multiplicand for requester i, in slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  multiplier for requester i, same slicing.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns rsp_result.
- rsp_result  out  2*WIDTH  unsigned product.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: sampled only at a rising edge with rst=0. Effects:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, req_ready=0.
  - Internal acc, multiplicand, multiplier and count cleared.
  - Reset mid-CALC or mid-DONE aborts the operation; no response is produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_ready is combinational.
  - Winner = first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ. Only the winner's req_ready bit is high; all bits are 0 if no request.
  - On an edge with req_valid[w]&req_ready[w], capture the operands:
    - multiplicand = zero-extend(req_a slice) to 2*WIDTH bits.
    - multiplier = req_b slice.
    - acc = 0, count = 0, rsp_id = w.
    - rr_ptr = (w+1) mod NREQ.
    - Go to CALC.
- CALC:
  - req_ready=0.
  - Each cycle:
    - if multiplier[0], acc += multiplicand (2*WIDTH-bit add, no overflow possible);
    - multiplicand <<= 1;
    - multiplier >>= 1;
    - count += 1.
  - Exit to DONE when count == WIDTH-1 (i.e. after exactly WIDTH CALC cycles).
  - On entry to DONE, rsp_result = final acc and rsp_valid=1.
  - Latency: accept edge E0 -> rsp_valid high after edge E0+WIDTH.
- DONE:
  - rsp_valid=1; rsp_result and rsp_id held stable; req_ready=0.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - No new request is accepted in the same cycle: one bubble cycle minimum between responses.
  - rsp_ready high before DONE has no effect.
- Requesters may drop req_valid before being granted without penalty. Operands are only sampled at the accept edge; later changes are ignored.
- busy = (state != IDLE).
- A requester whose req_valid stays high while another is served is guaranteed service within NREQ grants.

Optional Feature:
- Macro: MULT_ARB_EARLY_EXIT_EN.
- Defined: CALC also exits to DONE after any CALC cycle in which the updated multiplier becomes 0 (minimum 1 CALC cycle).
  - Latency = 1 + index of the highest set bit of b.
  - b=0 costs 1 cycle.
  - Result is identical to the full sequence.
- Undefined: fixed WIDTH-cycle CALC regardless of operands.

Test Plan:
- Reset then idle, no requests: req_ready=0, rsp_valid=0, busy=0, rsp_result=0 for 10 cycles.
- Single request, req0 a=7 b=9, rsp_ready=1: accepted at edge E0; rsp_valid after E0+4 with rsp_result=63, rsp_id=0; back to IDLE next edge. Also check a=15 b=15 -> 225 and a=0 b=13 -> 0.
- Both requesters held valid continuously with fresh operands, (3,5) and (6,7) then repeating: grants alternate 0,1,0,1; results 15(id0), 42(id1), 15, 42; never two req_ready bits high.
- Backpressure, req1 a=12 b=11: rsp_ready low for 5 cycles after rsp_valid. Required: rsp_result=132, rsp_id=1 held stable, req_ready=0 throughout; release rsp_ready -> rsp_valid drops next edge.
- Reset during CALC (rst=0 at 2nd CALC cycle): next cycle state IDLE, rsp_valid=0, busy=0, rr_ptr=0; a subsequent req0 5*3 returns 15 normally.
- Early-exit check, req0 a=5 b=1 and a=9 b=0:
  - with MULT_ARB_EARLY_EXIT_EN: rsp_valid after E0+1, results 5 and 0;
  - without it: rsp_valid after E0+4, same results.
